xoodoo_absorb_ctrl_sca: RTL and testbench
=========================================

XOODOO_ABSORB_CTRL_SCA -- requirements
Module: xoodoo_absorb_ctrl_SCA

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 12, maximum words absorbed per block (state lanes).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port blk_start_i  in  1  request to absorb one block; sampled only in IDLE.
REQ-005 SHALL have port blk_len_i  in  4  number of 64-bit share-pair words in the block.
REQ-006 SHALL have port blk_domain_i  in  32  domain constant XORed into lane 11 share 1 after the block.
REQ-007 SHALL have port blk_perm_i  in  1  1 = run the permutation after the domain injection.
REQ-008 SHALL have port din_data  in  64  {share0, share1} data word.
REQ-009 SHALL have port din_valid  in  1  din_data valid.
REQ-010 SHALL have port din_ready  out  1  block accepts din_data.
REQ-011 SHALL have port word_out  out  64  word to the state register, passed through from din_data.
REQ-012 SHALL have port word_index_out  out  4  target lane index.
REQ-013 SHALL have port word_enable_out  out  1  XOR word_out into lane word_index_out this cycle.
REQ-014 SHALL have port domain_out  out  32  latched domain constant.
REQ-015 SHALL have port domain_enable_out  out  1  XOR domain_out into lane 11 this cycle.
REQ-016 SHALL have port start_out  out  1  one-cycle permutation start pulse.
REQ-017 SHALL have port perm_done_i  in  1  permutation finished (one-cycle pulse from round controller).
REQ-018 SHALL have port busy_o  out  1  high in any state other than IDLE.
REQ-019 SHALL have port done_o  out  1  one-cycle pulse: block fully processed.

Function
REQ-020 SHALL implement FSM states IDLE, ABSORB, DOMAIN, START, WAIT, DONE.
REQ-021 IDLE: on blk_start_i SHALL latch len = min(blk_len_i, MAX_WORDS), domain and perm flag; clear word counter to 0; go to ABSORB if len>0, else DOMAIN.
REQ-022 ABSORB: din_ready SHALL be 1; word_enable_out SHALL equal din_valid & din_ready, combinationally, with zero added latency.
REQ-023 word_out SHALL equal din_data; word_index_out SHALL equal the word counter in all states, held when no transfer occurs.
REQ-024 On each transfer the counter SHALL increment; on the transfer where counter = len-1 the FSM SHALL go to DOMAIN and the counter SHALL stay at len-1.
REQ-025 din_ready SHALL be 0 in every state other than ABSORB; din_valid outside ABSORB SHALL be ignored.
REQ-026 DOMAIN: domain_enable_out SHALL be 1 for exactly one cycle, word_enable_out 0; next state START if perm flag, else DONE.
REQ-027 START: start_out SHALL be 1 for exactly one cycle; next state WAIT.
REQ-028 WAIT: SHALL hold until perm_done_i = 1, then go to DONE; perm_done_i in any other state SHALL be ignored.
REQ-029 DONE: done_o SHALL be 1 for one cycle; next state IDLE.
REQ-030 blk_start_i outside IDLE SHALL be ignored; the latched len, domain and flag SHALL not change while busy.
REQ-031 word_enable_out, domain_enable_out and start_out SHALL be mutually exclusive in every cycle.
REQ-032 Shares SHALL never be combined: no logic SHALL take share0 and share1 of din_data or domain as joint inputs.

Reset
REQ-033 rst SHALL force IDLE, counter 0, latched len 0, domain_out 0, flag 0, in the next cycle regardless of state.
REQ-034 After reset, din_ready, word_enable_out, domain_enable_out, start_out, busy_o, done_o SHALL be 0; word_index_out 0; word_out follows din_data.
REQ-035 rst asserted mid-block SHALL abandon the block with no further enable or start pulse; a pending perm_done_i SHALL be discarded.

Verification
REQ-036 len=3, domain=0x00000003, perm=1, din_valid continuous -> word_enable on 3 consecutive cycles, indices 0,1,2; then domain_enable 1 cycle; start_out 1 cycle; done_o 1 cycle after perm_done_i.
REQ-037 len=12 with din_valid toggling 1,0,1,0 -> exactly 12 enables, indices 0..11 strictly ascending, index held during gaps, din_ready stays 1 until the 12th transfer.
REQ-038 len=0, perm=0 -> no word_enable; domain_enable at cycle 1 after start, done_o at cycle 2; len=15 -> clamped to exactly 12 transfers.
REQ-039 blk_start_i pulsed again during ABSORB with a different len/domain -> ignored; the original len and domain are used.
REQ-040 rst asserted in WAIT, then perm_done_i pulsed -> IDLE, no done_o; a next block with len=1 completes normally.

Source files
------------

// File: rtl/xoodoo_absorb_ctrl_sca.sv
// Absorb controller for a masked Xoodoo state. It steers share-pair words into lanes, injects the
// domain constant into lane 11 share 1, and can kick off the permutation, one block at a time.
module xoodoo_absorb_ctrl_sca #(
    parameter int MAX_WORDS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        blk_start_i,
    input  logic [3:0]  blk_len_i,
    input  logic [31:0] blk_domain_i,
    input  logic        blk_perm_i,
    input  logic [63:0] din_data,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [63:0] word_out,
    output logic [3:0]  word_index_out,
    output logic        word_enable_out,
    output logic [31:0] domain_out,
    output logic        domain_enable_out,
    output logic        start_out,
    input  logic        perm_done_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {IDLE, ABSORB, DOMAIN, START, WAIT, DONE} state_t;

    localparam logic [3:0] MAX_LEN = 4'(MAX_WORDS);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [3:0]  len_reg;
    logic [31:0] domain_reg;
    logic        perm_reg;
    logic        din_ready_reg;
    logic        domain_en_reg;
    logic        start_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [3:0]  len_clamped;
    logic        transfer;

    assign len_clamped = (blk_len_i > MAX_LEN) ? MAX_LEN : blk_len_i;
    // The data word is never inspected; it only passes through, so the two shares stay apart.
    assign transfer    = din_valid & din_ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            len_reg       <= 4'd0;
            domain_reg    <= 32'd0;
            perm_reg      <= 1'b0;
            din_ready_reg <= 1'b0;
            domain_en_reg <= 1'b0;
            start_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (blk_start_i) begin
                        len_reg    <= len_clamped;
                        domain_reg <= blk_domain_i;
                        perm_reg   <= blk_perm_i;
                        cnt_reg    <= 4'd0;
                        busy_reg   <= 1'b1;
                        if (len_clamped != 4'd0) begin
                            state_reg     <= ABSORB;
                            din_ready_reg <= 1'b1;
                        end else begin
                            state_reg     <= DOMAIN;
                            domain_en_reg <= 1'b1;
                        end
                    end
                end
                ABSORB: begin
                    if (transfer) begin
                        // The counter parks on the last lane so the index stays meaningful.
                        if (cnt_reg == len_reg - 4'd1) begin
                            state_reg     <= DOMAIN;
                            din_ready_reg <= 1'b0;
                            domain_en_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                end
                DOMAIN: begin
                    domain_en_reg <= 1'b0;
                    if (perm_reg) begin
                        state_reg <= START;
                        start_reg <= 1'b1;
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                START: begin
                    start_reg <= 1'b0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (perm_done_i) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg     <= IDLE;
                    din_ready_reg <= 1'b0;
                    domain_en_reg <= 1'b0;
                    start_reg     <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready         = din_ready_reg;
    assign word_out          = din_data;
    assign word_index_out    = cnt_reg;
    assign word_enable_out   = transfer;
    assign domain_out        = domain_reg;
    assign domain_enable_out = domain_en_reg;
    assign start_out         = start_reg;
    assign busy_o            = busy_reg;
    assign done_o            = done_reg;

endmodule

// File: tb/tb_xoodoo_absorb_ctrl_sca.sv
// Directed bench for the absorb controller: table-driven blocks plus reset corner sequences.
module tb_xoodoo_absorb_ctrl_sca;

    logic        clk = 1'b0;
    logic        rst;
    logic        blk_start_i;
    logic [3:0]  blk_len_i;
    logic [31:0] blk_domain_i;
    logic        blk_perm_i;
    logic [63:0] din_data;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] word_out;
    logic [3:0]  word_index_out;
    logic        word_enable_out;
    logic [31:0] domain_out;
    logic        domain_enable_out;
    logic        start_out;
    logic        perm_done_i;
    logic        busy_o;
    logic        done_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xoodoo_absorb_ctrl_sca #(.MAX_WORDS(12)) dut (
        .clk               (clk),
        .rst               (rst),
        .blk_start_i       (blk_start_i),
        .blk_len_i         (blk_len_i),
        .blk_domain_i      (blk_domain_i),
        .blk_perm_i        (blk_perm_i),
        .din_data          (din_data),
        .din_valid         (din_valid),
        .din_ready         (din_ready),
        .word_out          (word_out),
        .word_index_out    (word_index_out),
        .word_enable_out   (word_enable_out),
        .domain_out        (domain_out),
        .domain_enable_out (domain_enable_out),
        .start_out         (start_out),
        .perm_done_i       (perm_done_i),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    // Cycle numbers count from the cycle in which blk_start_i is driven (cycle 0).
    typedef struct {
        logic [3:0]  len;
        logic [31:0] dom;
        logic        perm;
        logic        toggle;
        logic        restart;
        int          exp_we;
        int          exp_dom;
        int          exp_start;
        int          exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_block(input int id, input vec_t v);
        int n_we = 0, n_dom = 0, n_start = 0;
        int dom_cyc = 0, start_cyc = 0, done_cyc = 0;
        int prot_err = 0, bad = 0;
        logic [31:0] dom_seen = 32'd0;
        @(negedge clk);
        blk_start_i  = 1'b1;
        blk_len_i    = v.len;
        blk_domain_i = v.dom;
        blk_perm_i   = v.perm;
        din_valid    = 1'b0;
        perm_done_i  = 1'b0;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            @(negedge clk);
            blk_start_i = 1'b0;
            if (v.restart && c == 2) begin
                blk_start_i  = 1'b1;
                blk_len_i    = 4'd2;
                blk_domain_i = ~v.dom;
                blk_perm_i   = ~v.perm;
            end
            din_valid   = v.toggle ? (c % 2 == 1) : 1'b1;
            din_data    = {$urandom, $urandom};
            perm_done_i = (c == 1) || (start_cyc != 0 && c == start_cyc + 3);
            #1;
            if (!busy_o) prot_err++;
            if (32'(word_enable_out) + 32'(domain_enable_out) + 32'(start_out) > 1) prot_err++;
            if (din_ready) begin
                if (32'(word_index_out) != n_we) prot_err++;
            end else begin
                if (word_enable_out) prot_err++;
                if (32'(word_index_out) != ((n_we > 0) ? n_we - 1 : 0)) prot_err++;
            end
            if (word_enable_out) begin
                if (word_out !== din_data) prot_err++;
                n_we++;
            end
            if (domain_enable_out) begin
                n_dom++;
                dom_cyc  = c;
                dom_seen = domain_out;
            end
            if (start_out) begin
                n_start++;
                start_cyc = c;
            end
            if (done_o) done_cyc = c;
        end
        perm_done_i = 1'b0;
        din_valid   = 1'b0;
        check($sformatf("v%0d_enables", id), 64'(n_we), 64'(v.exp_we));
        check($sformatf("v%0d_dom_count", id), 64'(n_dom), 64'd1);
        check($sformatf("v%0d_dom_cycle", id), 64'(dom_cyc), 64'(v.exp_dom));
        check($sformatf("v%0d_dom_value", id), 64'(dom_seen), 64'(v.dom));
        check($sformatf("v%0d_start_count", id), 64'(n_start), 64'(v.perm ? 1 : 0));
        check($sformatf("v%0d_start_cycle", id), 64'(start_cyc), 64'(v.exp_start));
        check($sformatf("v%0d_done_cycle", id), 64'(done_cyc), 64'(v.exp_done));
        check($sformatf("v%0d_protocol", id), 64'(prot_err), 64'd0);
        @(negedge clk);
        #1;
        if (busy_o || done_o || din_ready || domain_enable_out || start_out) bad++;
        check($sformatf("v%0d_idle_after", id), 64'(bad), 64'd0);
        $display("[TB] vec %0d len=%0d perm=%0d we=%0d dom@%0d start@%0d done@%0d",
                 id, v.len, v.perm, n_we, dom_cyc, start_cyc, done_cyc);
    endtask

    initial begin
        int bad;
        vecs[0] = '{4'd3,  32'h0000_0003, 1'b1, 1'b0, 1'b0, 3,  4,  5,  9};
        vecs[1] = '{4'd12, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 12, 24, 0,  25};
        vecs[2] = '{4'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 0,  1,  0,  2};
        vecs[3] = '{4'd15, 32'h0000_0F0F, 1'b0, 1'b0, 1'b0, 12, 13, 0,  14};
        vecs[4] = '{4'd4,  32'h1234_5678, 1'b0, 1'b0, 1'b1, 4,  5,  0,  6};
        vecs[5] = '{4'd12, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 12, 13, 14, 18};
        vecs[6] = '{4'd1,  32'h0000_0001, 1'b1, 1'b0, 1'b0, 1,  2,  3,  7};

        rst          = 1'b1;
        blk_start_i  = 1'b0;
        blk_len_i    = 4'd0;
        blk_domain_i = 32'd0;
        blk_perm_i   = 1'b0;
        din_data     = 64'h0123_4567_89AB_CDEF;
        din_valid    = 1'b1;
        perm_done_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready",     64'(din_ready), 64'd0);
        check("rst_word_en",   64'(word_enable_out), 64'd0);
        check("rst_dom_en",    64'(domain_enable_out), 64'd0);
        check("rst_start",     64'(start_out), 64'd0);
        check("rst_busy",      64'(busy_o), 64'd0);
        check("rst_done",      64'(done_o), 64'd0);
        check("rst_index",     64'(word_index_out), 64'd0);
        check("rst_domain",    64'(domain_out), 64'd0);
        check("rst_word_pass", word_out, 64'h0123_4567_89AB_CDEF);
        din_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_block(i, vecs[i]);

        // Reset while waiting for the permutation, then a late perm_done_i pulse.
        @(negedge clk);
        blk_start_i  = 1'b1;
        blk_len_i    = 4'd1;
        blk_domain_i = 32'h0000_0005;
        blk_perm_i   = 1'b1;
        din_valid    = 1'b1;
        din_data     = 64'h1111_2222_3333_4444;
        @(negedge clk);
        blk_start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rw_start_pulse", 64'(start_out), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw_busy_in_wait", 64'(busy_o), 64'd1);
        @(negedge clk);
        rst         = 1'b0;
        perm_done_i = 1'b1;
        #1;
        check("rw_busy_cleared", 64'(busy_o), 64'd0);
        check("rw_domain_clear", 64'(domain_out), 64'd0);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            perm_done_i = 1'b0;
            #1;
            if (done_o || busy_o || word_enable_out || domain_enable_out || start_out) bad++;
        end
        check("rw_quiet_after", 64'(bad), 64'd0);
        din_valid = 1'b0;
        $display("[TB] reset-in-wait sequence quiet_cycles_bad=%0d", bad);

        run_block(7, vecs[6]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
